hilo_muldiv: RTL

- Iterative multiply/divide unit with architectural HI/LO registers for the MiniSys-1A datapath.
- Executes mult, multu, div, divu, mthi and mtlo.
- Drives the registered HI/LO values that the 32-bit writeback 2:1 selectors consume for mfhi/mflo.
- Sits beside the EX stage; the control unit stalls the pipeline while busy=1.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/restoring_divider.sv | 75 +++++++
 rtl/hilo_muldiv.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared constants, op encodings and FSM states for hilo_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int DATA_W   = 32;
    localparam int DIV_ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : restoring_divider
// Description : Unsigned restoring divider, one quotient bit per step.
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_divider #(
    parameter int DATA_W   = muldiv_pkg::DATA_W,
    parameter int DIV_ITER = muldiv_pkg::DIV_ITER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] r,
    output logic              last
);

    localparam int CNT_W = $clog2(DIV_ITER);

    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_trial;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        // quotient register doubles as the dividend shift source
        w_shift = {rem_q, quo_q[DATA_W-1]};
        w_trial = w_shift - {1'b0, dvs_q};
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = '0;
        end else if (step) begin
            if (!w_trial[DATA_W]) begin
                rem_d = w_trial[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_d = w_shift[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign q    = quo_q;
    assign r    = rem_q;
    assign last = (cnt_q == CNT_W'(DIV_ITER - 1));

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv
// Description : Iterative mult/multu/div/divu unit with architectural HI/LO.
//               HILO_BYPASS_EN forwards mthi/mtlo data onto hi/lo same-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv #(
    parameter int DATA_W   = muldiv_pkg::DATA_W,
    parameter int DIV_ITER = muldiv_pkg::DIV_ITER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              div0,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    import muldiv_pkg::*;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic                done_q, done_d;
    logic                div0_q, div0_d;

    logic                w_idle;
    logic                w_div_start;
    logic                w_div_last;
    logic                w_sgn_in;
    logic                w_sgn_div;
    logic                w_sgn_mul;
    logic [DATA_W-1:0]   w_dvd_abs;
    logic [DATA_W-1:0]   w_dvs_abs;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;
    logic [2*DATA_W-1:0] w_prod;

    assign w_idle    = (state_q == IDLE);
    assign w_sgn_in  = (op == OP_DIV);
    assign w_sgn_div = (op_q == OP_DIV);
    assign w_sgn_mul = (op_q == OP_MULT);

    assign w_dvd_abs = (w_sgn_in && a[DATA_W-1]) ? -a : a;
    assign w_dvs_abs = (w_sgn_in && b[DATA_W-1]) ? -b : b;

    // Extending both operands to 2*DATA_W makes one multiplier serve both signednesses
    assign w_prod = {{DATA_W{w_sgn_mul & a_q[DATA_W-1]}}, a_q}
                  * {{DATA_W{w_sgn_mul & b_q[DATA_W-1]}}, b_q};

    assign w_quo_fix = (w_sgn_div && (a_q[DATA_W-1] ^ b_q[DATA_W-1])) ? -w_quo : w_quo;
    assign w_rem_fix = (w_sgn_div && a_q[DATA_W-1]) ? -w_rem : w_rem;

    restoring_divider #(
        .DATA_W   (DATA_W),
        .DIV_ITER (DIV_ITER)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_div_start),
        .step     (state_q == DIV),
        .dividend (w_dvd_abs),
        .divisor  (w_dvs_abs),
        .q        (w_quo),
        .r        (w_rem),
        .last     (w_div_last)
    );

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        done_d      = 1'b0;
        div0_d      = div0_q;
        w_div_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    op_d   = op;
                    a_d    = a;
                    b_d    = b;
                    div0_d = 1'b0;
                    if (!op[1]) begin
                        state_d = MUL;
                    end else if (b == '0) begin
                        state_d = FIX;
                    end else begin
                        state_d     = DIV;
                        w_div_start = 1'b1;
                    end
                end
            end
            MUL: begin
                hi_d    = w_prod[2*DATA_W-1:DATA_W];
                lo_d    = w_prod[DATA_W-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            DIV: begin
                if (w_div_last) state_d = FIX;
            end
            FIX: begin
                // A zero divisor arrives here straight from IDLE with HI/LO untouched
                if (b_q == '0) begin
                    div0_d = 1'b1;
                end else begin
                    hi_d = w_rem_fix;
                    lo_d = w_quo_fix;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_MULT;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    assign busy = !w_idle;
    assign done = done_q;
    assign div0 = div0_q;

`ifdef HILO_BYPASS_EN
    assign hi = (hi_we && w_idle) ? wdata : hi_q;
    assign lo = (lo_we && w_idle) ? wdata : lo_q;
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

endmodule
`default_nettype wire
